// File: rtl/act_c2_cfg_loader.sv
// Serial configuration loader for an array of ACT C2 logic cells. It shifts in one
// parity-protected frame per cell, MSB-first, and writes each good frame to the config bank.
module act_c2_cfg_loader #(
  parameter int BITS   = 2,
  parameter int NCELLS = 4,
  parameter int ADDR_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic                cfg_we,
  output logic [ADDR_W-1:0]   cfg_addr,
  output logic [4*BITS+3:0]   cfg_data,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CFG_W   = 4*BITS+4;
  localparam int FRAME_W = CFG_W+1;
  localparam int CNT_W   = $clog2(FRAME_W+1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_W-1);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(NCELLS-1);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, WRITE} state_t;

  state_t               state;
  logic [ADDR_W-1:0]    cell_idx;
  logic [CNT_W-1:0]     bit_cnt;
  logic [FRAME_W-1:0]   shreg;

  // din_ready and busy are registered copies of the state, updated on every transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cell_idx  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      din_ready <= 1'b0;
      cfg_we    <= 1'b0;
      cfg_addr  <= '0;
      cfg_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      cfg_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            done      <= 1'b0;
            err       <= 1'b0;
            cell_idx  <= '0;
            bit_cnt   <= '0;
            din_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (din_valid) begin
            shreg   <= {shreg[FRAME_W-2:0], din};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state     <= CHECK;
              din_ready <= 1'b0;
            end
          end
        end
        CHECK: begin
          // Even parity over the whole frame; the parity bit itself is dropped on write
          if (^shreg) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cfg_we   <= 1'b1;
            cfg_addr <= cell_idx;
            cfg_data <= shreg[FRAME_W-1:1];
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (cell_idx == LAST_CELL) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cell_idx  <= cell_idx + 1'b1;
            bit_cnt   <= '0;
            din_ready <= 1'b1;
            state     <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_act_c2_cfg_loader.sv
// Self-checking bench for act_c2_cfg_loader: a queue of expected writes is filled as
// frames are driven and drained by a monitor whenever cfg_we is seen.
module tb_act_c2_cfg_loader;

  localparam int BITS    = 2;
  localparam int NCELLS  = 4;
  localparam int ADDR_W  = 2;
  localparam int CFG_W   = 4*BITS+4;
  localparam int FRAME_W = CFG_W+1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              din;
  logic              din_valid;
  logic              din_ready;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [CFG_W-1:0]  cfg_data;
  logic              busy;
  logic              done;
  logic              err;

  act_c2_cfg_loader #(.BITS(BITS), .NCELLS(NCELLS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc;
  int we_count;
  int first_we_cyc;
  int last_we_cyc;
  logic [ADDR_W+CFG_W-1:0] exp_q[$];
  logic [ADDR_W+CFG_W-1:0] mon_exp;
  logic [CFG_W-1:0]        pay [NCELLS];

  always @(posedge clk) cyc <= cyc + 1;

  // Every observed write is matched against the oldest expected {addr, data}
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cfg_we === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, required no write", cfg_addr, cfg_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({cfg_addr, cfg_data} !== mon_exp) begin
          n_fail++;
          $display("[TB] FAIL write_content: got addr=%0d data=%h, required addr=%0d data=%h",
                   cfg_addr, cfg_data, mon_exp[ADDR_W+CFG_W-1:CFG_W], mon_exp[CFG_W-1:0]);
        end
      end
      if (we_count == 0) first_we_cyc = cyc;
      last_we_cyc = cyc;
      we_count++;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic send_frame(input logic [CFG_W-1:0] p, input int addr, input bit bad_par,
                            input int max_bits, input bit gaps, input int start_at);
    logic [FRAME_W-1:0] f;
    int idx;
    int guard;
    idx   = 0;
    guard = 0;
    f = {p, (^p) ^ bad_par};
    while (idx < max_bits && guard < 1000) begin
      din_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      din       = din_valid ? f[FRAME_W-1-idx] : 1'($urandom);
      start     = (idx == start_at);
      if (din_valid && din_ready) begin
        if (idx == FRAME_W-1 && !bad_par) exp_q.push_back({ADDR_W'(addr), p});
        idx++;
      end
      @(posedge clk); #1;
      guard++;
    end
    din_valid = 1'b0;
    start     = 1'b0;
    if (guard >= 1000) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL frame_timeout: got %0d beats accepted, required %0d", idx, max_bits);
    end
  endtask

  task automatic wait_idle(output int t);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (busy && g < 200);
    t = cyc;
    if (busy) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL idle_timeout: got busy=%b, required 0", busy);
    end
  endtask

  task automatic check_done(input string name, input int writes);
    n_checks++;
    if ({done, err, busy} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL %s_flags: got done/err/busy=%b, required 100", name, {done, err, busy});
    end
    n_checks++;
    if (we_count !== writes || exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL %s_writes: got %0d writes (%0d pending), required %0d", name, we_count, exp_q.size(), writes);
    end
  endtask

  task automatic run_sequence(input bit gaps);
    for (int i = 0; i < NCELLS; i++) send_frame(pay[i], i, 1'b0, FRAME_W, gaps, -1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start = 1'($urandom); din = 1'($urandom); din_valid = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if ({din_ready, cfg_we, cfg_addr, cfg_data, busy, done, err} !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs: got %h, required 0", {din_ready, cfg_we, cfg_addr, cfg_data, busy, done, err});
      end
    end
    @(posedge clk); #1;
    start = 1'b0; din = 1'b0; din_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({busy, din_ready, done, err} !== 4'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_release: got busy/rdy/done/err=%b, required 0000", {busy, din_ready, done, err});
    end
  endtask

  task automatic test_happy();
    int t;
    we_count = 0;
    pulse_start();
    run_sequence(1'b0);
    wait_idle(t);
    check_done("happy", NCELLS);
    n_checks++;
    if (first_we_cyc - start_cyc !== FRAME_W+1) begin
      n_fail++;
      $display("[TB] FAIL first_write_latency: got %0d, required %0d", first_we_cyc - start_cyc, FRAME_W+1);
    end
    n_checks++;
    if (t !== last_we_cyc + 1) begin
      n_fail++;
      $display("[TB] FAIL done_latency: got %0d, required %0d", t - last_we_cyc, 1);
    end
  endtask

  task automatic test_parity();
    int t;
    we_count = 0;
    pulse_start();
    send_frame(pay[0], 0, 1'b0, FRAME_W, 1'b0, -1);
    send_frame(pay[1], 1, 1'b1, FRAME_W, 1'b0, -1);
    wait_idle(t);
    n_checks++;
    if ({err, done, din_ready} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL parity_flags: got err/done/rdy=%b, required 100", {err, done, din_ready});
    end
    din_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = 1'($urandom);
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (we_count !== 1 || busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL parity_writes: got %0d writes busy=%b, required 1 write busy=0", we_count, busy);
    end
  endtask

  task automatic test_stall();
    int t;
    we_count = 0;
    pulse_start();
    run_sequence(1'b1);
    wait_idle(t);
    check_done("stall", NCELLS);
  endtask

  task automatic test_reset_mid();
    int t;
    we_count = 0;
    pulse_start();
    send_frame(pay[0], 0, 1'b0, FRAME_W, 1'b0, -1);
    send_frame(pay[1], 1, 1'b0, FRAME_W, 1'b0, -1);
    send_frame(pay[2], 2, 1'b0, 6, 1'b0, -1);
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({din_ready, cfg_we, cfg_addr, cfg_data, busy, done, err} !== '0) begin
      n_fail++;
      $display("[TB] FAIL midreset_outputs: got %h, required 0", {din_ready, cfg_we, cfg_addr, cfg_data, busy, done, err});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (we_count !== 2 || exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL midreset_writes: got %0d writes, required 2", we_count);
    end
    we_count = 0;
    pulse_start();
    run_sequence(1'b0);
    wait_idle(t);
    check_done("reload", NCELLS);
  endtask

  task automatic test_start_busy();
    int t;
    we_count = 0;
    pulse_start();
    send_frame(pay[0], 0, 1'b0, FRAME_W, 1'b0, -1);
    send_frame(pay[1], 1, 1'b0, FRAME_W, 1'b0, 5);
    send_frame(pay[2], 2, 1'b0, FRAME_W, 1'b0, -1);
    send_frame(pay[3], 3, 1'b0, FRAME_W, 1'b0, -1);
    wait_idle(t);
    check_done("start_busy", NCELLS);
    we_count = 0;
    pulse_start();
    @(negedge clk);
    n_checks++;
    if ({done, busy, din_ready} !== 3'b011) begin
      n_fail++;
      $display("[TB] FAIL restart_flags: got done/busy/rdy=%b, required 011", {done, busy, din_ready});
    end
    @(posedge clk); #1;
    start_cyc = cyc - 1;
    run_sequence(1'b0);
    wait_idle(t);
    check_done("restart", NCELLS);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got simulation still running, required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; din = 1'b0; din_valid = 1'b0;
    we_count = 0; first_we_cyc = 0; last_we_cyc = 0; start_cyc = 0;
    pay[0] = 12'hA5C;
    pay[1] = 12'h3C1;
    pay[2] = 12'hFFE;
    pay[3] = 12'h807;
    test_reset();
    test_happy();
    test_parity();
    test_stall();
    test_reset_mid();
    test_start_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
